// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter.
// Shares the single regfile write port between the writeback stage (WB) and
// the multi-cycle multiply/divide unit (MDU). MDU results wait in a small
// FIFO and take idle write slots. A starvation counter stalls WB once a
// queued result has been denied for STARVE_LIMIT cycles. A per-register busy
// scoreboard tracks outstanding MDU destinations for decode hazard stalls.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   wb_valid/wb_index/wb_data        WB write request; wb_stall = hold WB
//   mdu_issue/mdu_issue_index        MDU issue (sets busy); mdu_issue_ready
//   mdu_valid/mdu_index/mdu_data     MDU result; mdu_ready = FIFO not full
//   hz_index_1/hz_index_2, hz_stall  decode source hazard check
//   wen/windex/wdata                 regfile write port (combinational)
//   waw_err                          sticky: WB wrote a busy register
module regfile_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_index,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_index,
  output logic        mdu_issue_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_index,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic [4:0]  hz_index_1,
  input  logic [4:0]  hz_index_2,
  output logic        hz_stall,
  output logic        wen,
  output logic [4:0]  windex,
  output logic [31:0] wdata,
  output logic        waw_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STV_ONE = SW'(1);

  logic [4:0]    fifo_idx  [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic [SW-1:0] starve_cnt;
  logic          waw_q;

  logic          empty;
  logic          full;
  logic          wb_req;
  logic          force_mdu;
  logic          grant_wb;
  logic          grant_mdu;
  logic          push;
  logic          issue_ok;
  logic          do_set;
  logic [4:0]    head_idx;
  logic [31:0]   head_data;

  always_comb begin
    empty     = (count == '0);
    full      = (count == DEPTH_C);
    head_idx  = fifo_idx[rd_ptr];
    head_data = fifo_data[rd_ptr];
    wb_req    = wb_valid && (wb_index != 5'd0);
    force_mdu = (starve_cnt >= LIMIT_C) && !empty;
    grant_wb  = wb_req && !force_mdu;
    grant_mdu = !grant_wb && !empty;
    // r0 results are acknowledged but never occupy a FIFO slot
    push      = mdu_valid && !full && (mdu_index != 5'd0);
    issue_ok  = !busy[mdu_issue_index] || (mdu_issue_index == 5'd0);
    do_set    = mdu_issue && issue_ok && (mdu_issue_index != 5'd0);

    busy_nxt = busy;
    if (grant_mdu) busy_nxt[head_idx] = 1'b0;
    if (do_set)    busy_nxt[mdu_issue_index] = 1'b1;
    busy_nxt[0] = 1'b0;

    wen             = !rst && (grant_wb || grant_mdu);
    windex          = grant_wb ? wb_index : head_idx;
    wdata           = grant_wb ? wb_data : head_data;
    wb_stall        = !rst && wb_req && grant_mdu;
    mdu_ready       = !rst && !full;
    mdu_issue_ready = !rst && issue_ok;
    // uses the pre-clear busy value: the regfile read this cycle is still stale
    hz_stall        = !rst && (busy[hz_index_1] || busy[hz_index_2]);
    waw_err         = waw_q;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_idx[wr_ptr]  <= mdu_index;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      starve_cnt <= '0;
      waw_q      <= 1'b0;
    end else begin
      if (push)      wr_ptr <= wr_ptr + PTR_ONE;
      if (grant_mdu) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, grant_mdu})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      busy <= busy_nxt;
      if (grant_mdu || empty)         starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + STV_ONE;
      if (grant_wb && busy[wb_index]) waw_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_index;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_index;
  logic        mdu_issue_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_index;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  hz_index_1;
  logic [4:0]  hz_index_2;
  logic        hz_stall;
  logic        wen;
  logic [4:0]  windex;
  logic [31:0] wdata;
  logic        waw_err;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t mdu_q[$];
  wr_t e;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  regfile_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data), .wb_stall(wb_stall),
    .mdu_issue(mdu_issue), .mdu_issue_index(mdu_issue_index), .mdu_issue_ready(mdu_issue_ready),
    .mdu_valid(mdu_valid), .mdu_index(mdu_index), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .hz_index_1(hz_index_1), .hz_index_2(hz_index_2), .hz_stall(hz_stall),
    .wen(wen), .windex(windex), .wdata(wdata), .waw_err(waw_err)
  );

  task automatic clear_inputs();
    wb_valid = 1'b0; wb_index = '0; wb_data = '0;
    mdu_issue = 1'b0; mdu_issue_index = '0;
    mdu_valid = 1'b0; mdu_index = '0; mdu_data = '0;
    hz_index_1 = '0; hz_index_2 = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wb_valid = 1'b1; wb_index = 5'd5; wb_data = 32'h11;
    mdu_valid = 1'b1; mdu_index = 5'd2; mdu_issue = 1'b1; mdu_issue_index = 5'd4;
    hz_index_1 = 5'd4;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL rst_wen: got %b want 0", wen); end
    vectors++; if (wb_stall !== 1'b0) begin miscompares++; $display("FAIL rst_wb_stall: got %b want 0", wb_stall); end
    vectors++; if (mdu_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mdu_ready: got %b want 0", mdu_ready); end
    vectors++; if (mdu_issue_ready !== 1'b0) begin miscompares++; $display("FAIL rst_issue_ready: got %b want 0", mdu_issue_ready); end
    vectors++; if (hz_stall !== 1'b0) begin miscompares++; $display("FAIL rst_hz_stall: got %b want 0", hz_stall); end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    mdu_q.delete();
    @(negedge clk);
    vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL idle_wen: got %b want 0", wen); end
    vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL idle_mdu_ready: got %b want 1", mdu_ready); end
    vectors++; if (hz_stall !== 1'b0) begin miscompares++; $display("FAIL idle_hz_stall: got %b want 0", hz_stall); end
    vectors++; if (waw_err !== 1'b0) begin miscompares++; $display("FAIL idle_waw_err: got %b want 0", waw_err); end
    vectors++; if (mdu_issue_ready !== 1'b1) begin miscompares++; $display("FAIL idle_issue_ready: got %b want 1", mdu_issue_ready); end
    next_cycle();
  endtask

  task automatic test_wb_write();
    wb_valid = 1'b1; wb_index = 5'd5; wb_data = 32'h11;
    @(negedge clk);
    vectors++;
    if (wen !== 1'b1 || windex !== 5'd5 || wdata !== 32'h11 || wb_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL wb_write: got wen=%b idx=%0d data=%h stall=%b want 1 5 00000011 0", wen, windex, wdata, wb_stall);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_mdu_hazard();
    mdu_issue = 1'b1; mdu_issue_index = 5'd8;
    @(negedge clk);
    vectors++; if (mdu_issue_ready !== 1'b1) begin miscompares++; $display("FAIL hz_issue_ready: got %b want 1", mdu_issue_ready); end
    next_cycle();
    mdu_issue = 1'b0; hz_index_1 = 5'd8;
    @(negedge clk);
    vectors++; if (hz_stall !== 1'b1) begin miscompares++; $display("FAIL hz_pending: got %b want 1", hz_stall); end
    next_cycle();
    mdu_valid = 1'b1; mdu_index = 5'd8; mdu_data = 32'hDEAD;
    mdu_q.push_back('{idx: 5'd8, data: 32'hDEAD});
    @(negedge clk);
    vectors++; if (mdu_ready !== 1'b1 || wen !== 1'b0) begin miscompares++; $display("FAIL hz_push: got ready=%b wen=%b want 1 0", mdu_ready, wen); end
    next_cycle();
    mdu_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mdu_q.size() == 0) begin miscompares++; $display("FAIL hz_mdu_write: scoreboard empty"); end
    else begin
      e = mdu_q.pop_front();
      if (wen !== 1'b1 || windex !== e.idx || wdata !== e.data) begin
        miscompares++; $display("FAIL hz_mdu_write: got wen=%b %0d/%h want 1 %0d/%h", wen, windex, wdata, e.idx, e.data);
      end
    end
    vectors++; if (hz_stall !== 1'b1) begin miscompares++; $display("FAIL hz_clear_cycle: got %b want 1", hz_stall); end
    next_cycle();
    @(negedge clk);
    vectors++; if (hz_stall !== 1'b0 || wen !== 1'b0) begin miscompares++; $display("FAIL hz_after: got hz=%b wen=%b want 0 0", hz_stall, wen); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starvation();
    wb_valid = 1'b1; wb_index = 5'd1; wb_data = 32'h100;
    mdu_valid = 1'b1; mdu_index = 5'd9; mdu_data = 32'h99;
    mdu_q.push_back('{idx: 5'd9, data: 32'h99});
    @(negedge clk);
    vectors++; if (wen !== 1'b1 || windex !== 5'd1 || wb_stall !== 1'b0) begin miscompares++; $display("FAIL stv_push_cycle: got wen=%b idx=%0d stall=%b want 1 1 0", wen, windex, wb_stall); end
    next_cycle();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wb_index = 5'(i + 1); wb_data = 32'h100 * (i + 1);
      @(negedge clk);
      vectors++;
      if (wen !== 1'b1 || windex !== 5'(i + 1) || wdata !== 32'h100 * (i + 1) || wb_stall !== 1'b0) begin
        miscompares++; $display("FAIL stv_wb_grant%0d: got wen=%b idx=%0d data=%h stall=%b want 1 %0d %h 0", i, wen, windex, wdata, wb_stall, i + 1, 32'h100 * (i + 1));
      end
      next_cycle();
    end
    wb_index = 5'd6; wb_data = 32'h600;
    @(negedge clk);
    vectors++; if (wb_stall !== 1'b1) begin miscompares++; $display("FAIL stv_force_stall: got %b want 1", wb_stall); end
    vectors++;
    if (mdu_q.size() == 0) begin miscompares++; $display("FAIL stv_force_write: scoreboard empty"); end
    else begin
      e = mdu_q.pop_front();
      if (wen !== 1'b1 || windex !== e.idx || wdata !== e.data) begin
        miscompares++; $display("FAIL stv_force_write: got wen=%b %0d/%h want 1 %0d/%h", wen, windex, wdata, e.idx, e.data);
      end
    end
    next_cycle();
    @(negedge clk);
    vectors++; if (wen !== 1'b1 || windex !== 5'd6 || wdata !== 32'h600 || wb_stall !== 1'b0) begin miscompares++; $display("FAIL stv_held_wb: got wen=%b idx=%0d data=%h stall=%b want 1 6 00000600 0", wen, windex, wdata, wb_stall); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    logic exp_ready;
    for (int c = 0; c < 10; c++) begin
      wb_valid = (c <= 6); wb_index = 5'd10; wb_data = 32'hA0A0;
      mdu_valid = (c <= 6);
      if (c == 0)      begin mdu_index = 5'd11; mdu_data = 32'hB1; end
      else if (c == 1) begin mdu_index = 5'd12; mdu_data = 32'hB2; end
      else             begin mdu_index = 5'd13; mdu_data = 32'hB3; end
      exp_ready = !(c >= 2 && c <= 5);
      if (c == 0 || c == 1 || c == 6) mdu_q.push_back('{idx: mdu_index, data: mdu_data});
      @(negedge clk);
      if (c <= 6) begin
        vectors++; if (mdu_ready !== exp_ready) begin miscompares++; $display("FAIL full_ready_c%0d: got %b want %b", c, mdu_ready, exp_ready); end
      end
      if (c == 5 || c == 7 || c == 8) begin
        vectors++;
        if (mdu_q.size() == 0) begin miscompares++; $display("FAIL full_drain_c%0d: scoreboard empty", c); end
        else begin
          e = mdu_q.pop_front();
          if (wen !== 1'b1 || windex !== e.idx || wdata !== e.data || wb_stall !== (c == 5)) begin
            miscompares++; $display("FAIL full_drain_c%0d: got wen=%b %0d/%h stall=%b want 1 %0d/%h %b", c, wen, windex, wdata, wb_stall, e.idx, e.data, c == 5);
          end
        end
      end else if (c <= 6) begin
        vectors++; if (wen !== 1'b1 || windex !== 5'd10 || wb_stall !== 1'b0) begin miscompares++; $display("FAIL full_wb_c%0d: got wen=%b idx=%0d stall=%b want 1 10 0", c, wen, windex, wb_stall); end
      end else begin
        vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL full_empty_c%0d: got wen=%b want 0", c, wen); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_issue_busy_waw();
    mdu_issue = 1'b1; mdu_issue_index = 5'd8;
    @(negedge clk);
    vectors++; if (mdu_issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_first_issue: got %b want 1", mdu_issue_ready); end
    next_cycle();
    @(negedge clk);
    vectors++; if (mdu_issue_ready !== 1'b0) begin miscompares++; $display("FAIL waw_busy_issue: got %b want 0", mdu_issue_ready); end
    next_cycle();
    mdu_issue = 1'b0;
    hz_index_1 = 5'd8; wb_valid = 1'b1; wb_index = 5'd8; wb_data = 32'h88;
    @(negedge clk);
    vectors++; if (hz_stall !== 1'b1) begin miscompares++; $display("FAIL waw_still_busy: got %b want 1", hz_stall); end
    vectors++; if (wen !== 1'b1 || windex !== 5'd8 || wdata !== 32'h88 || waw_err !== 1'b0) begin miscompares++; $display("FAIL waw_write: got wen=%b idx=%0d data=%h err=%b want 1 8 00000088 0", wen, windex, wdata, waw_err); end
    next_cycle();
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++; if (waw_err !== 1'b1) begin miscompares++; $display("FAIL waw_sticky%0d: got %b want 1", i, waw_err); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    mdu_issue = 1'b1; mdu_issue_index = 5'd3;
    wb_valid = 1'b1; wb_index = 5'd1; wb_data = 32'h1;
    mdu_valid = 1'b1; mdu_index = 5'd4; mdu_data = 32'h44;
    @(negedge clk);
    vectors++; if (wen !== 1'b1 || windex !== 5'd1 || mdu_issue_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_c0: got wen=%b idx=%0d iready=%b want 1 1 1", wen, windex, mdu_issue_ready); end
    next_cycle();
    mdu_issue = 1'b0; mdu_index = 5'd5; mdu_data = 32'h55;
    @(negedge clk);
    vectors++; if (mdu_ready !== 1'b1 || wen !== 1'b1 || windex !== 5'd1) begin miscompares++; $display("FAIL rmid_c1: got ready=%b wen=%b idx=%0d want 1 1 1", mdu_ready, wen, windex); end
    next_cycle();
    clear_inputs();
    rst = 1'b1; hz_index_1 = 5'd3;
    @(negedge clk);
    vectors++; if (wen !== 1'b0 || hz_stall !== 1'b0 || mdu_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_in_rst: got wen=%b hz=%b ready=%b want 0 0 0", wen, hz_stall, mdu_ready); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (wen !== 1'b0 || hz_stall !== 1'b0 || waw_err !== 1'b0 || mdu_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_after: got wen=%b hz=%b err=%b ready=%b want 0 0 0 1", wen, hz_stall, waw_err, mdu_ready); end
    next_cycle();
    hz_index_2 = 5'd8;
    @(negedge clk);
    vectors++; if (wen !== 1'b0 || hz_stall !== 1'b0) begin miscompares++; $display("FAIL rmid_busy8: got wen=%b hz=%b want 0 0", wen, hz_stall); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_r0();
    wb_valid = 1'b1; wb_index = 5'd0; wb_data = 32'hFFFF;
    mdu_valid = 1'b1; mdu_index = 5'd0; mdu_data = 32'h1234;
    mdu_issue = 1'b1; mdu_issue_index = 5'd0;
    @(negedge clk);
    vectors++; if (wen !== 1'b0 || wb_stall !== 1'b0) begin miscompares++; $display("FAIL r0_wb: got wen=%b stall=%b want 0 0", wen, wb_stall); end
    vectors++; if (mdu_ready !== 1'b1 || mdu_issue_ready !== 1'b1 || hz_stall !== 1'b0) begin miscompares++; $display("FAIL r0_flags: got ready=%b iready=%b hz=%b want 1 1 0", mdu_ready, mdu_issue_ready, hz_stall); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL r0_mdu_not_queued: got wen=%b want 0", wen); end
    next_cycle();
    mdu_valid = 1'b1; mdu_index = 5'd7; mdu_data = 32'h77;
    mdu_q.push_back('{idx: 5'd7, data: 32'h77});
    next_cycle();
    mdu_valid = 1'b0; wb_valid = 1'b1; wb_index = 5'd0;
    @(negedge clk);
    vectors++;
    if (mdu_q.size() == 0) begin miscompares++; $display("FAIL r0_mdu_slot: scoreboard empty"); end
    else begin
      e = mdu_q.pop_front();
      if (wen !== 1'b1 || windex !== e.idx || wdata !== e.data || wb_stall !== 1'b0) begin
        miscompares++; $display("FAIL r0_mdu_slot: got wen=%b %0d/%h stall=%b want 1 %0d/%h 0", wen, windex, wdata, wb_stall, e.idx, e.data);
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin
      mdu_valid = (c < 3);
      mdu_index = 5'(20 + c); mdu_data = 32'hC000 + 32'(c);
      if (c < 3) mdu_q.push_back('{idx: mdu_index, data: mdu_data});
      @(negedge clk);
      if (c < 3) begin
        vectors++; if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c%0d: got %b want 1", c, mdu_ready); end
      end
      if (c >= 1 && c <= 3) begin
        vectors++;
        if (mdu_q.size() == 0) begin miscompares++; $display("FAIL b2b_write_c%0d: scoreboard empty", c); end
        else begin
          e = mdu_q.pop_front();
          if (wen !== 1'b1 || windex !== e.idx || wdata !== e.data) begin
            miscompares++; $display("FAIL b2b_write_c%0d: got wen=%b %0d/%h want 1 %0d/%h", c, wen, windex, wdata, e.idx, e.data);
          end
        end
      end else begin
        vectors++; if (wen !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_c%0d: got wen=%b want 0", c, wen); end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_wb_write();
    test_mdu_hazard();
    test_starvation();
    test_fifo_full();
    test_issue_busy_waw();
    test_reset_mid();
    test_r0();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
